apb3_hub: RTL and testbench
===========================

Name: apb3_hub

Overview:
- Parametrised APB3 slave-side hub for the fabric peripheral bank (neopixel, servo, rsa, nfc and later blocks).
- Decodes PADDR into NUM_SLOTS equal-sized peripheral windows and broadcasts the bus to each slot.
- Muxes read data, ready and error back from the selected slot. Adds slave wait-state support, an access timeout and error response for unmapped addresses.
- Hosts a small interrupt controller that aggregates NUM_IRQ external request pins onto the FABINT line to the MSS.

Parameters:
- ADDR_W, 8: PADDR width.
- SLOT_AW, 4: log2 of bytes per slot window. The slot index is PADDR[ADDR_W-1:SLOT_AW].
- NUM_SLOTS, 6: number of peripheral slots. Legal range is 1 .. 2^(ADDR_W-SLOT_AW)-1.
- NUM_IRQ, 4: number of external interrupt inputs, 1..31.
- TIMEOUT_CYCLES, 16: maximum ACCESS-phase cycles with slot PREADY low before the hub aborts the access. Must be >= 2.

Ports:
- PCLK  in  1  bus clock; all logic is on the rising edge.
- PRESETN  in  1  asynchronous active-low reset.
- PSEL  in  1  APB select from the MSS.
- PENABLE  in  1  APB enable.
- PWRITE  in  1  1 = write.
- PADDR  in  ADDR_W  byte address.
- PWDATA  in  32  write data.
- PRDATA  out  32  read data to the MSS.
- PREADY  out  1  transfer complete.
- PSLVERR  out  1  transfer error.
- SL_PSEL  out  NUM_SLOTS  one-hot slot select.
- SL_PENABLE  out  1  broadcast enable, asserted only in ACCESS.
- SL_PWRITE  out  1  broadcast PWRITE.
- SL_PADDR  out  SLOT_AW  offset within the slot.
- SL_PWDATA  out  32  broadcast PWDATA.
- SL_PRDATA  in  32*NUM_SLOTS  slot i occupies bits [32i+31:32i].
- SL_PREADY  in  NUM_SLOTS  per-slot ready.
- SL_PSLVERR  in  NUM_SLOTS  per-slot error.
- IRQ_IN  in  NUM_IRQ  asynchronous interrupt pins (e.g. NFC IRQ).
- FABINT  out  1  aggregated interrupt to the MSS.

Behaviour:
- Reset state:
  - FSM in IDLE; timeout counter 0.
  - IRQ_STATUS, IRQ_MASK and IRQ_MODE all 0; synchronizers 0.
  - PREADY=0, PSLVERR=0, PRDATA=0, SL_PSEL=0, SL_PENABLE=0, FABINT=0.
  - Reset mid-transfer aborts immediately. There is no completion response; the bus restarts in IDLE.
- Address map:
  - idx = PADDR[ADDR_W-1:SLOT_AW].
  - idx < NUM_SLOTS selects slot idx.
  - idx = 2^(ADDR_W-SLOT_AW)-1 (0xF0-0xFF at defaults) selects the hub registers.
  - Any other idx is unmapped.
- FSM states:
  - IDLE: move to SETUP on PSEL & !PENABLE.
  - SETUP: latch decode into sel_q. Drive SL_PSEL[idx]=1 for a slot, with SL_PENABLE=0. Always move to ACCESS next cycle.
  - ACCESS: SL_PENABLE=1 for a slot target.
    - Slot target: PREADY = SL_PREADY[sel_q], PSLVERR = SL_PSLVERR[sel_q] & PREADY, PRDATA = slot data.
    - Hub register or unmapped target: PREADY=1 in the first ACCESS cycle (zero wait states).
    - Unmapped target: PSLVERR=1 and PRDATA=0. A write to an unmapped address has no effect.
    - When PREADY=1: go to SETUP if PSEL is still high with a new transfer, otherwise IDLE. Drop SL_PSEL in IDLE.
- Timeout:
  - The counter increments every ACCESS cycle while slot PREADY is low.
  - When the count reaches TIMEOUT_CYCLES-1 with PREADY still low, the hub forces PREADY=1, PSLVERR=1, PRDATA=0, and sets IRQ_STATUS[NUM_IRQ] (TIMEOUT flag).
  - The counter clears on leaving ACCESS.
  - A slot PREADY arriving in the same cycle as timeout expiry wins: normal completion, no flag.
- PRDATA outside ACCESS is 0.
- Hub registers (offset within the top window):
  - 0x0 IRQ_RAW (RO): synchronized IRQ_IN.
  - 0x4 IRQ_STATUS (W1C): bits [NUM_IRQ-1:0] are interrupts, bit NUM_IRQ is TIMEOUT.
  - 0x8 IRQ_MASK (RW): NUM_IRQ+1 bits.
  - 0xC IRQ_MODE (RW): per-IRQ mode, 0 = level, 1 = rising edge.
  - Unimplemented bits read 0. Writes commit at the ACCESS cycle with PREADY=1.
- IRQ path:
  - Each IRQ_IN goes through a 2-flop synchronizer followed by a delay flop for edge detection.
  - Set condition: level mode sets while the synchronized bit is 1; edge mode sets when the synchronized bit is 1 and the delay flop is 0.
  - A pin high at edge k sets the status bit at edge k+2.
  - Set has priority over a same-cycle W1C clear. A level-mode bit therefore cannot be cleared while its source is still high.
- FABINT = |(IRQ_STATUS & IRQ_MASK), a combinational OR of registers. There is no glitch from the synchronizers.

Test Plan:
- Write 0xDEADBEEF to 0x14 with slot 1 SL_PREADY=1 -> SL_PSEL=6'b000010 for 2 cycles, SL_PADDR=0x4, PREADY in the first ACCESS cycle, PSLVERR=0.
- Read 0x23 with slot 2 holding SL_PREADY low for 3 cycles, SL_PRDATA=0x12345678 -> PREADY on the 4th ACCESS cycle, PRDATA=0x12345678.
- Read slot 0 with SL_PREADY stuck low -> PREADY=PSLVERR=1 on ACCESS cycle 16, PRDATA=0, IRQ_STATUS=0x10. Then set MASK=0x10 -> FABINT=1; W1C 0x10 -> FABINT=0.
- Write or read 0x80 (unmapped) -> zero-wait PREADY, PSLVERR=1, PRDATA=0, no SL_PSEL bit asserted.
- MODE=0x1, MASK=0x1, pulse IRQ_IN[0] high 1 cycle -> STATUS=0x1 two edges later, FABINT=1. Hold IRQ_IN[1] high in level mode -> W1C of bit 1 is ignored until the pin drops.
- Assert PRESETN low during a waited ACCESS -> all outputs 0 asynchronously; the next transfer completes normally.

Source files
------------

// File: rtl/apb3_hub.sv
// APB3 hub: decodes the bus into NUM_SLOTS peripheral windows plus a hub register window,
// adds wait-state/timeout handling and a small interrupt controller driving FABINT.
module apb3_hub #(
  parameter int ADDR_W         = 8,
  parameter int SLOT_AW        = 4,
  parameter int NUM_SLOTS      = 6,
  parameter int NUM_IRQ        = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    PCLK,
  input  logic                    PRESETN,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [ADDR_W-1:0]       PADDR,
  input  logic [31:0]             PWDATA,
  output logic [31:0]             PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR,
  output logic [NUM_SLOTS-1:0]    SL_PSEL,
  output logic                    SL_PENABLE,
  output logic                    SL_PWRITE,
  output logic [SLOT_AW-1:0]      SL_PADDR,
  output logic [31:0]             SL_PWDATA,
  input  logic [32*NUM_SLOTS-1:0] SL_PRDATA,
  input  logic [NUM_SLOTS-1:0]    SL_PREADY,
  input  logic [NUM_SLOTS-1:0]    SL_PSLVERR,
  input  logic [NUM_IRQ-1:0]      IRQ_IN,
  output logic                    FABINT
);

  localparam int IDX_W = ADDR_W - SLOT_AW;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [IDX_W-1:0] HUB_IDX = '1;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_e;
  typedef enum logic [1:0] {T_SLOT, T_HUB, T_NONE} tgt_e;

  state_e               state_q;
  tgt_e                 tgt_q;
  logic [IDX_W-1:0]     sel_q;
  logic [NUM_SLOTS-1:0] sl_psel_q;
  logic                 sl_penable_q;
  logic [CNT_W-1:0]     tmo_q;

  logic [NUM_IRQ-1:0]   sync1_q, sync2_q, dly_q, mode_q;
  logic [NUM_IRQ:0]     status_q, status_d, mask_q, irq_set, irq_clr;

  logic [IDX_W-1:0]     idx;
  logic [SLOT_AW-1:0]   off;
  tgt_e                 dec_tgt;
  logic [NUM_SLOTS-1:0] dec_onehot;
  logic                 slot_rdy, slot_err;
  logic [31:0]          slot_rdata, hub_rdata;
  logic                 access, bus_act, tmo_hit, hub_wr;

  assign idx     = PADDR[ADDR_W-1:SLOT_AW];
  assign off     = PADDR[SLOT_AW-1:0];
  assign access  = (state_q == S_ACCESS);
  assign bus_act = (state_q != S_IDLE);

  always_comb begin
    dec_onehot = '0;
    for (int i = 0; i < NUM_SLOTS; i++)
      if (idx == IDX_W'(i)) dec_onehot[i] = 1'b1;
    if ({1'b0, idx} < (IDX_W+1)'(NUM_SLOTS)) dec_tgt = T_SLOT;
    else if (idx == HUB_IDX)                 dec_tgt = T_HUB;
    else                                     dec_tgt = T_NONE;
  end

  always_comb begin
    slot_rdy   = 1'b0;
    slot_err   = 1'b0;
    slot_rdata = '0;
    for (int i = 0; i < NUM_SLOTS; i++)
      if (sel_q == IDX_W'(i)) begin
        slot_rdy   = SL_PREADY[i];
        slot_err   = SL_PSLVERR[i];
        slot_rdata = SL_PRDATA[32*i +: 32];
      end
  end

  // A slot ready in the expiry cycle wins over the timeout.
  assign tmo_hit = access && (tgt_q == T_SLOT) && !slot_rdy &&
                   (tmo_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    hub_rdata = '0;
    if      (off == SLOT_AW'(0))  hub_rdata = 32'(sync2_q);
    else if (off == SLOT_AW'(4))  hub_rdata = 32'(status_q);
    else if (off == SLOT_AW'(8))  hub_rdata = 32'(mask_q);
    else if (off == SLOT_AW'(12)) hub_rdata = 32'(mode_q);
  end

  always_comb begin
    PREADY  = 1'b0;
    PSLVERR = 1'b0;
    PRDATA  = '0;
    if (access) begin
      case (tgt_q)
        T_SLOT: begin
          PREADY  = slot_rdy | tmo_hit;
          PSLVERR = (slot_err & slot_rdy) | tmo_hit;
          PRDATA  = tmo_hit ? 32'h0 : slot_rdata;
        end
        T_HUB: begin
          PREADY = 1'b1;
          PRDATA = hub_rdata;
        end
        default: begin
          PREADY  = 1'b1;
          PSLVERR = 1'b1;
        end
      endcase
    end
  end

  assign SL_PSEL    = sl_psel_q;
  assign SL_PENABLE = sl_penable_q;
  assign SL_PWRITE  = bus_act & PWRITE;
  assign SL_PADDR   = bus_act ? off : '0;
  assign SL_PWDATA  = bus_act ? PWDATA : '0;

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      state_q      <= S_IDLE;
      tgt_q        <= T_NONE;
      sel_q        <= '0;
      sl_psel_q    <= '0;
      sl_penable_q <= 1'b0;
      tmo_q        <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (PSEL && !PENABLE) begin
            state_q   <= S_SETUP;
            tgt_q     <= dec_tgt;
            sel_q     <= idx;
            sl_psel_q <= (dec_tgt == T_SLOT) ? dec_onehot : '0;
          end
        end
        S_SETUP: begin
          state_q      <= S_ACCESS;
          sl_penable_q <= (tgt_q == T_SLOT);
          tmo_q        <= '0;
        end
        S_ACCESS: begin
          if (PREADY) begin
            sl_penable_q <= 1'b0;
            sl_psel_q    <= '0;
            tmo_q        <= '0;
            state_q      <= S_IDLE;
            if (PSEL && !PENABLE) begin
              state_q   <= S_SETUP;
              tgt_q     <= dec_tgt;
              sel_q     <= idx;
              sl_psel_q <= (dec_tgt == T_SLOT) ? dec_onehot : '0;
            end
          end else begin
            tmo_q <= tmo_q + CNT_W'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign hub_wr = access && (tgt_q == T_HUB) && PWRITE;

  always_comb begin
    irq_set = '0;
    for (int i = 0; i < NUM_IRQ; i++)
      irq_set[i] = mode_q[i] ? (sync2_q[i] & ~dly_q[i]) : sync2_q[i];
    irq_set[NUM_IRQ] = tmo_hit;
    irq_clr  = (hub_wr && off == SLOT_AW'(4)) ? PWDATA[NUM_IRQ:0] : '0;
    // Set beats a same-cycle clear, so a held level source stays pending.
    status_d = (status_q & ~irq_clr) | irq_set;
  end

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      dly_q    <= '0;
      status_q <= '0;
      mask_q   <= '0;
      mode_q   <= '0;
    end else begin
      sync1_q  <= IRQ_IN;
      sync2_q  <= sync1_q;
      dly_q    <= sync2_q;
      status_q <= status_d;
      if (hub_wr && off == SLOT_AW'(8))  mask_q <= PWDATA[NUM_IRQ:0];
      if (hub_wr && off == SLOT_AW'(12)) mode_q <= PWDATA[NUM_IRQ-1:0];
    end
  end

  assign FABINT = |(status_q & mask_q);

endmodule

// File: tb/tb_apb3_hub.sv
// Directed bench for apb3_hub: slot transfers, wait states, timeout, unmapped access,
// interrupt controller and asynchronous reset mid-transfer.
module tb_apb3_hub;
  localparam int NS = 6;
  localparam int NI = 4;

  logic              PCLK = 1'b0;
  logic              PRESETN = 1'b0;
  logic              PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [7:0]        PADDR = '0;
  logic [31:0]       PWDATA = '0;
  logic [31:0]       PRDATA;
  logic              PREADY, PSLVERR;
  logic [NS-1:0]     SL_PSEL;
  logic              SL_PENABLE, SL_PWRITE;
  logic [3:0]        SL_PADDR;
  logic [31:0]       SL_PWDATA;
  logic [32*NS-1:0]  SL_PRDATA;
  logic [NS-1:0]     SL_PREADY;
  logic [NS-1:0]     SL_PSLVERR = '0;
  logic [NI-1:0]     IRQ_IN = '0;
  logic              FABINT;

  logic [31:0] slot_data [NS];
  int          wait_cfg  [NS];
  int          acc_cnt   [NS];

  int n_cmp = 0;
  int n_mis = 0;

  apb3_hub dut (
    .PCLK(PCLK), .PRESETN(PRESETN), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .SL_PSEL(SL_PSEL), .SL_PENABLE(SL_PENABLE), .SL_PWRITE(SL_PWRITE), .SL_PADDR(SL_PADDR),
    .SL_PWDATA(SL_PWDATA), .SL_PRDATA(SL_PRDATA), .SL_PREADY(SL_PREADY),
    .SL_PSLVERR(SL_PSLVERR), .IRQ_IN(IRQ_IN), .FABINT(FABINT)
  );

  always #5 PCLK = ~PCLK;

  // Slot model: ready once the slot has seen wait_cfg ACCESS cycles.
  always_comb begin
    for (int i = 0; i < NS; i++) begin
      SL_PRDATA[32*i +: 32] = slot_data[i];
      SL_PREADY[i]          = (acc_cnt[i] >= wait_cfg[i]);
    end
  end

  always @(posedge PCLK) begin
    for (int i = 0; i < NS; i++)
      acc_cnt[i] <= (SL_PSEL[i] && SL_PENABLE) ? acc_cnt[i] + 1 : 0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic apb(input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                     output logic [31:0] rd, output logic err, output int acc,
                     output int psel_cyc, output logic [NS-1:0] psel_or,
                     output logic [3:0] spaddr, output logic [31:0] spwdata);
    int n;
    bit done;
    rd = '0; err = 1'b0; acc = 0; psel_cyc = 0; psel_or = '0; spaddr = '0; spwdata = '0;
    n = 0; done = 1'b0;
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wd;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    while (!done && n < 100) begin
      @(negedge PCLK);
      n++;
      if (SL_PSEL != '0) psel_cyc++;
      psel_or |= SL_PSEL;
      if (PREADY) begin
        rd = PRDATA; err = PSLVERR; acc = n - 1;
        spaddr = SL_PADDR; spwdata = SL_PWDATA; done = 1'b1;
      end
    end
    if (!done) check("bus_no_ready", 32'(PREADY), 32'h1);
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic reg_wr(input logic [7:0] addr, input logic [31:0] wd);
    logic [31:0] rd; logic err; int acc, pc; logic [NS-1:0] po; logic [3:0] sa; logic [31:0] sw;
    apb(1'b1, addr, wd, rd, err, acc, pc, po, sa, sw);
  endtask

  task automatic reg_rd(input logic [7:0] addr, output logic [31:0] rd);
    logic err; int acc, pc; logic [NS-1:0] po; logic [3:0] sa; logic [31:0] sw;
    apb(1'b0, addr, 32'h0, rd, err, acc, pc, po, sa, sw);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0]   rd, sw;
    logic          err;
    int            acc, pc;
    logic [NS-1:0] po;
    logic [3:0]    sa;

    for (int i = 0; i < NS; i++) begin
      slot_data[i] = 32'hC0DE0000 | 32'(i);
      wait_cfg[i]  = 0;
      acc_cnt[i]   = 0;
    end
    slot_data[0] = 32'hA5A5A5A5;
    slot_data[2] = 32'h12345678;

    // Reset state
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    check("rst_pready",  32'(PREADY),     32'h0);
    check("rst_pslverr", 32'(PSLVERR),    32'h0);
    check("rst_prdata",  PRDATA,          32'h0);
    check("rst_sl_psel", 32'(SL_PSEL),    32'h0);
    check("rst_sl_pen",  32'(SL_PENABLE), 32'h0);
    check("rst_fabint",  32'(FABINT),     32'h0);
    @(posedge PCLK); #1;
    PRESETN = 1'b1;

    // Zero-wait write to slot 1
    apb(1'b1, 8'h14, 32'hDEADBEEF, rd, err, acc, pc, po, sa, sw);
    check("wr_s1_acc",      32'(acc), 32'd1);
    check("wr_s1_psel_cyc", 32'(pc),  32'd2);
    check("wr_s1_psel",     32'(po),  32'h02);
    check("wr_s1_paddr",    32'(sa),  32'h4);
    check("wr_s1_pwdata",   sw,       32'hDEADBEEF);
    check("wr_s1_err",      32'(err), 32'h0);

    // Slot 2 with three wait states
    wait_cfg[2] = 3;
    apb(1'b0, 8'h23, 32'h0, rd, err, acc, pc, po, sa, sw);
    check("rd_s2_acc",   32'(acc), 32'd4);
    check("rd_s2_data",  rd,       32'h12345678);
    check("rd_s2_err",   32'(err), 32'h0);
    check("rd_s2_paddr", 32'(sa),  32'h3);

    // Slot error passthrough
    SL_PSLVERR[1] = 1'b1;
    apb(1'b1, 8'h10, 32'h1, rd, err, acc, pc, po, sa, sw);
    check("s1_slverr", 32'(err), 32'h1);
    SL_PSLVERR[1] = 1'b0;

    // Timeout on slot 0
    wait_cfg[0] = 1000;
    apb(1'b0, 8'h00, 32'h0, rd, err, acc, pc, po, sa, sw);
    check("tmo_acc",  32'(acc), 32'd16);
    check("tmo_err",  32'(err), 32'h1);
    check("tmo_data", rd,       32'h0);
    apb(1'b0, 8'hF4, 32'h0, rd, err, acc, pc, po, sa, sw);
    check("tmo_status", rd,       32'h10);
    check("hub_rd_acc", 32'(acc), 32'd1);
    check("hub_rd_err", 32'(err), 32'h0);
    check("hub_rd_psel", 32'(po), 32'h0);
    reg_wr(8'hF8, 32'h10);
    @(negedge PCLK);
    check("tmo_fabint_on", 32'(FABINT), 32'h1);
    reg_wr(8'hF4, 32'h10);
    @(negedge PCLK);
    check("tmo_fabint_off", 32'(FABINT), 32'h0);

    // Unmapped window
    apb(1'b1, 8'h80, 32'hFFFFFFFF, rd, err, acc, pc, po, sa, sw);
    check("unm_wr_acc",  32'(acc), 32'd1);
    check("unm_wr_err",  32'(err), 32'h1);
    check("unm_wr_psel", 32'(po),  32'h0);
    apb(1'b0, 8'h84, 32'h0, rd, err, acc, pc, po, sa, sw);
    check("unm_rd_acc",  32'(acc), 32'd1);
    check("unm_rd_err",  32'(err), 32'h1);
    check("unm_rd_data", rd,       32'h0);

    // Edge-mode IRQ 0
    reg_wr(8'hFC, 32'h1);
    reg_wr(8'hF8, 32'h1);
    reg_rd(8'hFC, rd);
    check("mode_rb", rd, 32'h1);
    reg_rd(8'hF8, rd);
    check("mask_rb", rd, 32'h1);
    @(posedge PCLK); #1;
    IRQ_IN[0] = 1'b1;
    @(posedge PCLK); #1;
    IRQ_IN[0] = 1'b0;
    @(negedge PCLK);
    check("edge_k0", 32'(FABINT), 32'h0);
    @(negedge PCLK);
    check("edge_k1", 32'(FABINT), 32'h0);
    @(negedge PCLK);
    check("edge_k2", 32'(FABINT), 32'h1);
    reg_rd(8'hF4, rd);
    check("edge_status", rd, 32'h1);
    reg_wr(8'hF4, 32'h1);
    reg_rd(8'hF4, rd);
    check("edge_cleared", rd, 32'h0);

    // Level-mode IRQ 1 held high
    IRQ_IN[1] = 1'b1;
    repeat (4) @(posedge PCLK);
    #1;
    reg_rd(8'hF0, rd);
    check("raw_lvl", rd, 32'h2);
    reg_rd(8'hF4, rd);
    check("lvl_status", rd, 32'h2);
    reg_wr(8'hF4, 32'h2);
    reg_rd(8'hF4, rd);
    check("lvl_w1c_held", rd, 32'h2);
    IRQ_IN[1] = 1'b0;
    repeat (4) @(posedge PCLK);
    #1;
    reg_wr(8'hF4, 32'h2);
    reg_rd(8'hF4, rd);
    check("lvl_w1c_dropped", rd, 32'h0);

    // Leave IRQ 0 pending so reset has something to clear
    IRQ_IN[0] = 1'b1;
    repeat (4) @(posedge PCLK);
    #1;
    IRQ_IN[0] = 1'b0;
    @(negedge PCLK);
    check("pre_rst_fabint", 32'(FABINT), 32'h1);

    // Reset during a waited slot-0 access
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 8'h08;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    repeat (4) @(negedge PCLK);
    check("pre_rst_prdata", PRDATA,          32'hA5A5A5A5);
    check("pre_rst_psel",   32'(SL_PSEL),    32'h01);
    check("pre_rst_pready", 32'(PREADY),     32'h0);
    #1;
    PRESETN = 1'b0;
    #1;
    check("arst_pready",  32'(PREADY),     32'h0);
    check("arst_pslverr", 32'(PSLVERR),    32'h0);
    check("arst_prdata",  PRDATA,          32'h0);
    check("arst_sl_psel", 32'(SL_PSEL),    32'h0);
    check("arst_sl_pen",  32'(SL_PENABLE), 32'h0);
    check("arst_fabint",  32'(FABINT),     32'h0);
    PSEL = 1'b0; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    PRESETN = 1'b1;
    apb(1'b1, 8'h14, 32'h0BADF00D, rd, err, acc, pc, po, sa, sw);
    check("post_rst_acc",  32'(acc), 32'd1);
    check("post_rst_err",  32'(err), 32'h0);
    check("post_rst_psel", 32'(po),  32'h02);
    reg_rd(8'hF4, rd);
    check("post_rst_status", rd, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
